// File: rtl/dda_pkg.sv
// Shared constants for the Lorenz DDA UART parameter loader: frame bytes, command codes,
// register file size and reset contents, and the parser state type.
package dda_pkg;

    localparam int REG_SIZE = 14;
    localparam int TIMEOUT_CYCLES = 50000;
    localparam logic [8*REG_SIZE-1:0] DEFAULT_PARAMS = 112'hC000_14CD_7240_6A00_5555_7300_0400;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_BULK    = 8'h01;
    localparam logic [7:0] CMD_SINGLE  = 8'h02;
    localparam logic [7:0] CMD_RUN     = 8'h03;
    localparam logic [7:0] CMD_HALT    = 8'h04;
    localparam logic [7:0] CMD_RESTART = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } parser_state_t;

    function automatic logic cmd_known(input logic [7:0] code);
        return (code >= CMD_BULK) && (code <= CMD_RESTART);
    endfunction

endpackage

// File: rtl/dda_param_loader.sv
// UART frame parser that stages payloads in a shadow buffer and commits them atomically
// to the DDA parameter file; also owns DDA run/halt and the IC-reload strobe.
module dda_param_loader #(
    parameter int REG_SIZE = dda_pkg::REG_SIZE,
    parameter int TIMEOUT_CYCLES = dda_pkg::TIMEOUT_CYCLES,
    parameter logic [8*REG_SIZE-1:0] DEFAULT_PARAMS = dda_pkg::DEFAULT_PARAMS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_error,
    output logic [8*REG_SIZE-1:0] params,
    output logic                  en_dda,
    output logic                  dda_restart,
    output logic                  ack,
    output logic                  nack,
    output logic                  busy
);
    import dda_pkg::*;

    localparam int IW = $clog2(REG_SIZE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    parser_state_t         state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            chk_q, chk_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            shadow_q [REG_SIZE];
    logic [7:0]            shadow_d [REG_SIZE];
    logic [8*REG_SIZE-1:0] params_q, params_d;
    logic                  en_q, en_d;
    logic                  restart_q, restart_d;
    logic                  ack_q, ack_d;
    logic                  nack_q, nack_d;

    logic                  byte_vld;
    logic [IW-1:0]         plen;

    // A byte arriving together with a framing error is corrupt and never parsed.
    assign byte_vld = rx_valid && !rx_error;
    assign plen     = (cmd_q == CMD_BULK) ? IW'(REG_SIZE) : IW'(2);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        params_d  = params_q;
        en_d      = en_q;
        restart_d = 1'b0;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        tmo_d     = (state_q == ST_IDLE || rx_valid) ? '0 : tmo_q + TW'(1);

        if (state_q != ST_IDLE && rx_error) begin
            nack_d  = 1'b1;
            state_d = ST_IDLE;
        end else if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (cmd_known(rx_byte)) begin
                        cmd_d   = rx_byte;
                        chk_d   = rx_byte;
                        idx_d   = '0;
                        state_d = (rx_byte == CMD_BULK || rx_byte == CMD_SINGLE) ? ST_PAYLOAD : ST_CHK;
                    end else begin
                        nack_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    shadow_d[idx_q] = rx_byte;
                    chk_d           = chk_q ^ rx_byte;
                    idx_d           = idx_q + IW'(1);
                    if (idx_q == plen - IW'(1)) state_d = ST_CHK;
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (rx_byte != chk_q) begin
                        nack_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        case (cmd_q)
                            CMD_BULK: begin
                                for (int i = 0; i < REG_SIZE; i++)
                                    params_d[8*(REG_SIZE-i)-1 -: 8] = shadow_q[i];
                            end
                            CMD_SINGLE: begin
                                // Shadow slot 0 holds ADDR, slot 1 holds DATA.
                                if (shadow_q[0] >= 8'(REG_SIZE)) begin
                                    ack_d  = 1'b0;
                                    nack_d = 1'b1;
                                end else begin
                                    for (int i = 0; i < REG_SIZE; i++)
                                        if (shadow_q[0] == 8'(i))
                                            params_d[8*(REG_SIZE-i)-1 -: 8] = shadow_q[1];
                                end
                            end
                            CMD_RUN:     en_d      = 1'b1;
                            CMD_HALT:    en_d      = 1'b0;
                            CMD_RESTART: restart_d = 1'b1;
                            default:     ;
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            nack_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            for (int i = 0; i < REG_SIZE; i++) shadow_q[i] <= '0;
            params_q  <= DEFAULT_PARAMS;
            en_q      <= 1'b1;
            restart_q <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            shadow_q  <= shadow_d;
            params_q  <= params_d;
            en_q      <= en_d;
            restart_q <= restart_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
        end
    end

    assign params      = params_q;
    assign en_dda      = en_q;
    assign dda_restart = restart_q;
    assign ack         = ack_q;
    assign nack        = nack_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dda_param_loader.sv
// Directed bench for dda_param_loader: hand-built frames with precomputed expected parameter images.
module tb_dda_param_loader;

    localparam int RS = 14;
    localparam int TMO = 50000;
    localparam logic [8*RS-1:0] DEF = 112'hC000_14CD_7240_6A00_5555_7300_0400;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_byte = 8'h00;
    logic            rx_error = 1'b0;
    logic [8*RS-1:0] params;
    logic            en_dda;
    logic            dda_restart;
    logic            ack;
    logic            nack;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8*RS-1:0] exp_p;

    dda_param_loader dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_error    (rx_error),
        .params      (params),
        .en_dda      (en_dda),
        .dda_restart (dda_restart),
        .ack         (ack),
        .nack        (nack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Presents one byte for one clock; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_error = err;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic set_byte(input int i, input logic [7:0] v);
        exp_p[8*(RS-i)-1 -: 8] = v;
    endtask

    initial begin
        int cyc;
        exp_p = DEF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_params", params, exp_p);
        check("rst_en", en_dda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_acknack", {ack, nack, dda_restart}, 3'b000);

        // SINGLE write: sigma high byte (byte 6) <- 0x70
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h70, 1'b0);
        check("single_busy", busy, 1'b1);
        check("single_pre", params, exp_p);
        send_byte(8'h74, 1'b0);
        set_byte(6, 8'h70);
        check("single_acknack", {ack, nack}, 2'b10);
        check("single_params", params, 112'hC000_14CD_7240_7000_5555_7300_0400);
        @(negedge clk);
        check("single_ack_pulse", {ack, nack, busy}, 3'b000);

        // Bad checksum
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h70, 1'b0);
        send_byte(8'h75, 1'b0);
        check("badchk_acknack", {ack, nack}, 2'b01);
        check("badchk_params", params, exp_p);

        // BULK 0x00..0x0D, checksum 0x00
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
        for (int i = 0; i < RS; i++) send_byte(8'(i), 1'b0);
        check("bulk_pre", params, exp_p);
        send_byte(8'h00, 1'b0);
        exp_p = 112'h0001_0203_0405_0607_0809_0A0B_0C0D;
        check("bulk_acknack", {ack, nack}, 2'b10);
        check("bulk_params", params, exp_p);

        // 0xA5 as payload data, byte 3
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'hA5, 1'b0);
        send_byte(8'hA4, 1'b0);
        set_byte(3, 8'hA5);
        check("a5data_acknack", {ack, nack}, 2'b10);
        check("a5data_params", params, exp_p);

        // HALT, RESTART, RUN
        send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h04, 1'b0);
        check("halt", {ack, nack, en_dda}, 3'b100);
        send_byte(8'hA5, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h05, 1'b0);
        check("restart", {ack, nack, dda_restart, en_dda}, 4'b1010);
        @(negedge clk);
        check("restart_pulse", {ack, dda_restart, en_dda}, 3'b000);
        send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h03, 1'b0);
        check("run", {ack, nack, en_dda}, 3'b101);

        // SINGLE with out-of-range address
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h0E, 1'b0); send_byte(8'h11, 1'b0);
        send_byte(8'h1D, 1'b0);
        check("badaddr_acknack", {ack, nack}, 2'b01);
        check("badaddr_params", params, exp_p);

        // Unknown command code
        send_byte(8'hA5, 1'b0); send_byte(8'h07, 1'b0);
        check("badcmd", {ack, nack, busy}, 3'b010);

        // Non-sync byte in IDLE is ignored
        send_byte(8'h3C, 1'b0);
        check("idle_junk", {ack, nack, busy}, 3'b000);

        // Timeout mid-BULK
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        cyc = 0;
        for (int k = 1; k <= TMO + 100; k++) begin
            @(negedge clk);
            if (nack || ack || !busy) begin
                cyc = k;
                break;
            end
        end
        check("tmo_cycles", cyc, TMO);
        check("tmo_acknack", {ack, nack, busy}, 3'b010);
        check("tmo_params", params, exp_p);

        // rx_error coincident with third payload byte
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("rxerr_acknack", {ack, nack, busy}, 3'b010);
        check("rxerr_params", params, exp_p);
        send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h04, 1'b0);
        check("rxerr_recover", {ack, nack, en_dda}, 3'b100);

        // Reset mid-frame restores defaults and enable
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst", {params, en_dda, busy, ack, nack}, {DEF, 4'b1000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
